speed_loop_sequencer: RTL and testbench

//  Sequences one closed-loop motor speed update per sample period and owns the goal setpoint.
//  - Each sample: step the goal from the up/down buttons, latch the measured speed and form the error.
//  - Borrow the shared 9x9 signed multiplier through a req/ack handshake to compute gain*error.
//  - Scale and saturate the product, then publish the duty cycle consumed by the PWM block.

---
 rtl/speed_loop_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_speed_loop_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_loop_sequencer.sv
// -----------------------------------------------------------------------------
// speed_loop_sequencer
//
// Purpose:
//   Runs one closed-loop motor speed update per sample period and owns the
//   goal setpoint. Each sample it steps the goal from the up/down buttons,
//   latches the measured speed, forms the error, borrows the shared 9x9
//   signed multiplier through a req/ack handshake to compute gain*error,
//   then scales and saturates the product into the duty command that the
//   PWM block consumes.
//
// Parameters:
//   SAMPLE_PERIOD  clk cycles per control update (minimum 8)
//   GOAL_LIMIT     symmetric goal clamp magnitude (1..127)
//   SHIFT          arithmetic right shift applied to the product (0..16)
//
// Optional feature:
//   MUL_TIMEOUT_EN  when defined, a multiplier that never acks is abandoned
//                   after 255 cycles: duty is forced to 0, duty_valid pulses
//                   and the sticky fault flag is set. When undefined the
//                   sequencer waits for ack indefinitely and fault is 0.
//
// Ports:
//   clk             in   1   system clock
//   reset           in   1   asynchronous, active-high
//   count_up        in   1   level, raise goal by 1 at the next sample
//   count_down      in   1   level, lower goal by 1 at the next sample
//   gain            in   8   unsigned loop gain
//   measured_speed  in   8   signed feedback speed
//   mul_req         out  1   multiplier request
//   mul_a           out  9   signed operand A = {1'b0, gain}
//   mul_b           out  9   signed operand B = error
//   mul_ack         in   1   multiplier grant / result valid
//   mul_p           in   18  signed product, valid with mul_ack
//   duty_cycle      out  8   signed duty command, held between updates
//   duty_valid      out  1   1-cycle pulse when duty_cycle updates
//   goal            out  8   signed current setpoint
//   busy            out  1   high whenever an update is in progress
//   overrun         out  1   1-cycle pulse when a tick arrives while busy
//   fault           out  1   sticky multiplier timeout flag
// -----------------------------------------------------------------------------
module speed_loop_sequencer #(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int GOAL_LIMIT    = 127,
    parameter int SHIFT         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               count_up,
    input  logic               count_down,
    input  logic [7:0]         gain,
    input  logic signed [7:0]  measured_speed,
    output logic               mul_req,
    output logic signed [8:0]  mul_a,
    output logic signed [8:0]  mul_b,
    input  logic               mul_ack,
    input  logic signed [17:0] mul_p,
    output logic signed [7:0]  duty_cycle,
    output logic               duty_valid,
    output logic signed [7:0]  goal,
    output logic               busy,
    output logic               overrun,
    output logic               fault
);

    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic signed [7:0] GOAL_MAX = 8'(GOAL_LIMIT);
    localparam logic signed [7:0] GOAL_MIN = -GOAL_MAX;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_ERROR  = 3'd2,
        S_MUL    = 3'd3,
        S_SCALE  = 3'd4,
        S_UPDATE = 3'd5
    } state_t;

    // Arithmetic shift (floor) followed by a symmetric clamp; -128 is never
    // produced so the PWM block sees a balanced command range.
    function automatic logic signed [7:0] scale_sat(input logic signed [17:0] p);
        logic signed [17:0] s;
        s = p >>> SHIFT;
        if (s > 18'sd127) begin
            return 8'sd127;
        end else if (s < -18'sd127) begin
            return -8'sd127;
        end else begin
            return s[7:0];
        end
    endfunction

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;

    logic signed [7:0]  goal_q, goal_d;
    logic signed [8:0]  mul_a_q, mul_a_d;
    logic signed [8:0]  mul_b_q, mul_b_d;
    logic signed [7:0]  duty_q, duty_d;
    logic               duty_valid_q, duty_valid_d;
    logic               fault_q, fault_d;

    // Data-only registers: their contents are always rewritten before use.
    logic [7:0]         gain_lat_q, gain_lat_d;
    logic signed [7:0]  speed_lat_q, speed_lat_d;
    logic signed [17:0] prod_q, prod_d;

    logic signed [8:0]  err;
    logic               mul_timeout;

`ifdef MUL_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    // Last permitted MUL cycle is wait_q == 254, i.e. 255 cycles with req high.
    assign mul_timeout = (state_q == S_MUL) && !mul_ack && (wait_q == 8'd254);

    always_comb begin
        wait_d = wait_q;
        if (state_q == S_ERROR) begin
            wait_d = 8'd0;
        end else if (state_q == S_MUL) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign mul_timeout = 1'b0;
`endif

    // Free-running sample-period counter; never paused by a busy FSM.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Exact 9-bit error; goal_q already holds this sample's stepped value.
    assign err = {goal_q[7], goal_q} - {speed_lat_q[7], speed_lat_q};

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_ERROR;
            S_ERROR:  state_d = S_MUL;
            S_MUL: begin
                if (mul_ack) begin
                    state_d = S_SCALE;
                end else if (mul_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_SCALE:  state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs decoded from state. mul_req comes straight from the state
    // register so an asynchronous reset drops it immediately.
    always_comb begin
        mul_req = (state_q == S_MUL);
        busy    = (state_q != S_IDLE);
        overrun = tick && (state_q != S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        goal_d       = goal_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        fault_d      = fault_q;
        gain_lat_d   = gain_lat_q;
        speed_lat_d  = speed_lat_q;
        prod_d       = prod_q;

        case (state_q)
            S_SAMPLE: begin
                gain_lat_d  = gain;
                speed_lat_d = measured_speed;
                // Up has priority; each direction only moves inside the clamp.
                if (count_up) begin
                    if (goal_q < GOAL_MAX) goal_d = goal_q + 8'sd1;
                end else if (count_down) begin
                    if (goal_q > GOAL_MIN) goal_d = goal_q - 8'sd1;
                end
            end
            S_ERROR: begin
                // Operands are registered here and held for the whole MUL state.
                mul_a_d = {1'b0, gain_lat_q};
                mul_b_d = err;
            end
            S_MUL: begin
                if (mul_ack) begin
                    prod_d = mul_p;
                end else if (mul_timeout) begin
                    duty_d       = 8'sd0;
                    duty_valid_d = 1'b1;
                    fault_d      = 1'b1;
                end
            end
            S_SCALE: begin
                // Registered on leaving SCALE so the new duty and its valid
                // pulse appear together during UPDATE.
                duty_d       = scale_sat(prod_q);
                duty_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            goal_q       <= 8'sd0;
            mul_a_q      <= 9'sd0;
            mul_b_q      <= 9'sd0;
            duty_q       <= 8'sd0;
            duty_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            goal_q       <= goal_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            fault_q      <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        gain_lat_q  <= gain_lat_d;
        speed_lat_q <= speed_lat_d;
        prod_q      <= prod_d;
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign duty_cycle = duty_q;
    assign duty_valid = duty_valid_q;
    assign goal       = goal_q;

`ifdef MUL_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_speed_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_speed_loop_sequencer
//
// Directed bench for speed_loop_sequencer with SAMPLE_PERIOD=8. A small
// multiplier responder answers mul_req with the exact signed product when
// acks are enabled. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_speed_loop_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               count_up;
    logic               count_down;
    logic [7:0]         gain;
    logic signed [7:0]  measured_speed;
    logic               mul_req;
    logic signed [8:0]  mul_a;
    logic signed [8:0]  mul_b;
    logic               mul_ack = 1'b0;
    logic signed [17:0] mul_p = '0;
    logic signed [7:0]  duty_cycle;
    logic               duty_valid;
    logic signed [7:0]  goal;
    logic               busy;
    logic               overrun;
    logic               fault;

    logic ack_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    speed_loop_sequencer #(
        .SAMPLE_PERIOD(8),
        .GOAL_LIMIT   (127),
        .SHIFT        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .count_up      (count_up),
        .count_down    (count_down),
        .gain          (gain),
        .measured_speed(measured_speed),
        .mul_req       (mul_req),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_ack       (mul_ack),
        .mul_p         (mul_p),
        .duty_cycle    (duty_cycle),
        .duty_valid    (duty_valid),
        .goal          (goal),
        .busy          (busy),
        .overrun       (overrun),
        .fault         (fault)
    );

    // Shared multiplier stand-in: answers on the opposite edge so the ack is
    // seen at the first rising edge of the MUL state.
    always @(negedge clk) begin
        mul_ack = ack_en && mul_req;
        mul_p   = mul_req ? 18'($signed(mul_a) * $signed(mul_b)) : 18'sd0;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_rise();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 40);
        check("busy_seen", int'(busy), 1);
    endtask

    task automatic wait_mul_req(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mul_req && cyc < 40);
        check("mul_req_seen", int'(mul_req), 1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!duty_valid && cyc < 40);
        check("valid_seen", int'(duty_valid), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ovr;
        int stable;

        reset          = 1'b1;
        count_up       = 1'b0;
        count_down     = 1'b0;
        gain           = 8'd0;
        measured_speed = 8'sd0;
        repeat (3) @(negedge clk);

        check("rst_mul_req",    int'(mul_req), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_goal",       int'(goal), 0);
        check("rst_duty",       int'(duty_cycle), 0);
        check("rst_duty_valid", int'(duty_valid), 0);
        check("rst_overrun",    int'(overrun), 0);
        check("rst_fault",      int'(fault), 0);

        reset  = 1'b0;
        ack_en = 1'b1;

        // gain=16, speed=40, goal=0: err=-40, p=-640, >>>8 = -3
        gain           = 8'd16;
        measured_speed = 8'sd40;
        wait_busy_rise();
        wait_mul_req(c);
        check("lat_busy_to_req", c, 2);
        check("t3_mul_a", int'(mul_a), 16);
        check("t3_mul_b", int'(mul_b), -40);
        wait_valid(c);
        check("lat_req_to_valid", c, 2);
        check("t3_duty", int'(duty_cycle), -3);
        check("t3_goal", int'(goal), 0);
        @(negedge clk);
        check("t3_valid_pulse", int'(duty_valid), 0);
        check("t3_duty_hold", int'(duty_cycle), -3);

        // Ramp goal up for 130 samples; clamp holds it at 127.
        gain           = 8'd0;
        measured_speed = 8'sd0;
        count_up       = 1'b1;
        for (int i = 0; i < 130; i++) wait_valid(c);
        check("t4_goal_max", int'(goal), 127);
        count_up = 1'b0;

        // gain=255, speed=-127, goal=127: err=254, p=64770, >>>8=253 -> +127
        gain           = 8'd255;
        measured_speed = -8'sd127;
        wait_busy_rise();
        wait_mul_req(c);
        check("t2_lat_req", c, 2);
        check("t2_mul_a", int'(mul_a), 255);
        check("t2_mul_b", int'(mul_b), 254);
        wait_valid(c);
        check("t2_lat_valid", c, 2);
        check("t2_duty_sat", int'(duty_cycle), 127);
        check("t2_goal", int'(goal), 127);

        // Ramp down 122 samples: 127 -> 5, then both buttons: up wins -> 6.
        gain           = 8'd0;
        measured_speed = 8'sd0;
        count_down     = 1'b1;
        for (int i = 0; i < 122; i++) wait_valid(c);
        check("t4_goal_5", int'(goal), 5);
        count_up = 1'b1;
        wait_valid(c);
        check("t4_up_wins", int'(goal), 6);
        count_up   = 1'b0;
        count_down = 1'b0;

        // gain=255, speed=127, goal=6: err=-121, p=-30855, floor(/256)=-121
        gain           = 8'd255;
        measured_speed = 8'sd127;
        wait_valid(c);
        check("neg_duty", int'(duty_cycle), -121);

        // Withhold ack across the next tick: gain=200, speed=-100, goal=6
        // err=106, p=21200, >>>8 = 82
        ack_en         = 1'b0;
        gain           = 8'd200;
        measured_speed = -8'sd100;
        wait_mul_req(c);
        check("t5_mul_a", int'(mul_a), 200);
        check("t5_mul_b", int'(mul_b), 106);
        ovr    = 0;
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (overrun) ovr++;
            if (mul_a !== 9'sd200 || mul_b !== 9'sd106 || !mul_req) stable = 0;
        end
        check("t5_overrun_once", ovr, 1);
        check("t5_operands_stable", stable, 1);
        ack_en = 1'b1;
        wait_valid(c);
        check("t5_late_duty", int'(duty_cycle), 82);
        check("fault_after_late_ack", int'(fault), 0);

        // Reset in the middle of MUL
        ack_en = 1'b0;
        wait_mul_req(c);
        reset = 1'b1;
        #1;
        check("t1_req_drop", int'(mul_req), 0);
        check("t1_goal", int'(goal), 0);
        check("t1_duty", int'(duty_cycle), 0);
        @(negedge clk);
        reset  = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        check("t1_busy", int'(busy), 0);
        check("t1_req_after", int'(mul_req), 0);

`ifdef MUL_TIMEOUT_EN
        // Establish a nonzero duty first (goal 0, gain 16, speed 40 -> -3).
        gain           = 8'd16;
        measured_speed = 8'sd40;
        wait_valid(c);
        check("t6_pre_duty", int'(duty_cycle), -3);
        ack_en = 1'b0;
        wait_mul_req(c);
        c = 1;
        while (mul_req && c < 400) begin
            @(negedge clk);
            if (mul_req) c++;
        end
        check("t6_req_cycles", c, 255);
        check("t6_valid", int'(duty_valid), 1);
        check("t6_duty_zero", int'(duty_cycle), 0);
        check("t6_fault", int'(fault), 1);
        ack_en = 1'b1;
        wait_valid(c);
        check("t6_resume_duty", int'(duty_cycle), -3);
        check("t6_fault_sticky", int'(fault), 1);
`else
        check("fault_tied_low", int'(fault), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
